// File: rtl/process_scheduler_if.sv
// rtl/process_scheduler_if.sv - Scheduler <-> processor/boot-logic signal bundle
//
// Purpose: groups every non-clock signal exchanged by process_scheduler with the
// ProgramCounter halt/load path and the boot logic. Suffixes are from the
// scheduler's point of view (_i = into scheduler, _o = out of scheduler).
//
// Modports:
//   master : processor / boot side (drives enable, PC, halt, ready, exit, ack)
//   slave  : process_scheduler
//
// Signals:
//   enable_i       scheduler active; low = single-task mode
//   current_pc_i   ProgramCounter output
//   halted_i       processor halted (I/O wait) this cycle
//   proc_ready_i   bitmap of slots holding a loaded program
//   proc_exit_i    one-cycle pulse: running process finished
//   preempt_ack_i  processor stopped at an instruction boundary
//   preempt_req_o  stop request to PC halt path
//   load_pc_o      one-cycle pulse: PC <= new_pc_o
//   new_pc_o       PC to load, valid while load_pc_o
//   pid_o          running process id
//   idle_o         no live process / scheduler inactive
interface process_scheduler_if #(
  parameter int NPROC = 4,
  parameter int PID_W = 2
);
  logic             enable_i;
  logic [31:0]      current_pc_i;
  logic             halted_i;
  logic [NPROC-1:0] proc_ready_i;
  logic             proc_exit_i;
  logic             preempt_ack_i;
  logic             preempt_req_o;
  logic             load_pc_o;
  logic [31:0]      new_pc_o;
  logic [PID_W-1:0] pid_o;
  logic             idle_o;

  modport master (
    output enable_i, current_pc_i, halted_i, proc_ready_i, proc_exit_i, preempt_ack_i,
    input  preempt_req_o, load_pc_o, new_pc_o, pid_o, idle_o
  );

  modport slave (
    input  enable_i, current_pc_i, halted_i, proc_ready_i, proc_exit_i, preempt_ack_i,
    output preempt_req_o, load_pc_o, new_pc_o, pid_o, idle_o
  );
endinterface

// File: rtl/process_scheduler.sv
// rtl/process_scheduler.sv - Round-robin quantum scheduler with per-process saved-PC table
//
// Purpose: counts the running process's time slice; on expiry or exit it asks
// the processor to stop at an instruction boundary, saves the stopped PC,
// picks the next live slot round-robin and pulses a PC load with that slot's
// saved PC. All outputs are registered.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     process_scheduler_if.slave (see interface file for signal list)
//
// Optional feature: define SCHED_HALT_PREEMPT_EN to make Halted=1 in RUN yield
// the processor at once (PC saved, not marked exited). Without it Halted only
// freezes the quantum counter.
module process_scheduler #(
  parameter int          NPROC   = 4,
  parameter int          PID_W   = 2,
  parameter int          QUANTUM = 16,
  parameter logic [31:0] STRIDE  = 32'd1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  process_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SAVE,
    S_SELECT,
    S_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NPROC-1:0] exited_q, exited_d;
  logic             exit_cause_q, exit_cause_d;
  logic [31:0]      pc_table_q [NPROC];
  logic             save_en;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             preempt_req_q, preempt_req_d;
  logic             load_pc_q, load_pc_d;
  logic             idle_q, idle_d;

  logic [NPROC-1:0] live;
  logic             sel_found;
  logic [PID_W-1:0] sel_pid;
  logic [PID_W-1:0] probe;
  logic             expire;

  assign live = bus.proc_ready_i & ~exited_q;

  // Round-robin search starting after the current PID; the last probe wraps
  // (PID_W-bit truncation) back onto the current PID itself.
  always_comb begin
    sel_found = 1'b0;
    sel_pid   = pid_q;
    probe     = pid_q;
    for (int k = 1; k <= NPROC; k++) begin
      probe = pid_q + PID_W'(k);
      if (!sel_found && live[probe]) begin
        sel_found = 1'b1;
        sel_pid   = probe;
      end
    end
  end

`ifdef SCHED_HALT_PREEMPT_EN
  assign expire = bus.proc_exit_i | bus.halted_i | (cnt_q == 8'd0);
`else
  assign expire = bus.proc_exit_i | (!bus.halted_i && (cnt_q == 8'd0));
`endif

  always_comb begin
    state_d      = state_q;
    pid_d        = pid_q;
    cnt_d        = cnt_q;
    exited_d     = exited_q;
    exit_cause_d = exit_cause_q;
    new_pc_d     = new_pc_q;
    save_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable_i && (live != '0)) state_d = S_SELECT;
      end
      S_RUN: begin
        if (!bus.enable_i) begin
          state_d = S_IDLE;
        end else begin
          if (!bus.halted_i && (cnt_q != 8'd0)) cnt_d = cnt_q - 8'd1;
          if (expire) begin
            state_d      = S_DRAIN;
            // Exit wins over a simultaneous quantum/halt expiry.
            exit_cause_d = bus.proc_exit_i;
          end
        end
      end
      S_DRAIN: begin
        if (bus.preempt_ack_i) state_d = S_SAVE;
      end
      S_SAVE: begin
        if (exit_cause_q) exited_d[pid_q] = 1'b1;
        else              save_en         = 1'b1;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          state_d  = S_LOAD;
          pid_d    = sel_pid;
          new_pc_d = pc_table_q[sel_pid];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = 8'(QUANTUM - 1);
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    preempt_req_d = (state_d == S_DRAIN) || (state_d == S_SAVE) ||
                    (state_d == S_SELECT) || (state_d == S_LOAD);
    load_pc_d     = (state_d == S_LOAD);
    idle_d        = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pid_q         <= PID_W'(NPROC - 1);
      cnt_q         <= 8'd0;
      exited_q      <= '0;
      exit_cause_q  <= 1'b0;
      new_pc_q      <= 32'd0;
      preempt_req_q <= 1'b0;
      load_pc_q     <= 1'b0;
      idle_q        <= 1'b1;
      for (int i = 0; i < NPROC; i++) begin
        pc_table_q[i] <= 32'(i) * STRIDE;
      end
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      cnt_q         <= cnt_d;
      exited_q      <= exited_d;
      exit_cause_q  <= exit_cause_d;
      new_pc_q      <= new_pc_d;
      preempt_req_q <= preempt_req_d;
      load_pc_q     <= load_pc_d;
      idle_q        <= idle_d;
      if (save_en) pc_table_q[pid_q] <= bus.current_pc_i;
    end
  end

  assign bus.preempt_req_o = preempt_req_q;
  assign bus.load_pc_o     = load_pc_q;
  assign bus.new_pc_o      = new_pc_q;
  assign bus.pid_o         = pid_q;
  assign bus.idle_o        = idle_q;

endmodule

// File: tb/tb_process_scheduler.sv
// tb/tb_process_scheduler.sv - Self-checking bench for process_scheduler
module tb_process_scheduler;

  localparam int QUANTUM = 16;

`ifdef SCHED_HALT_PREEMPT_EN
  localparam bit RH = 1'b0;
`else
  localparam bit RH = 1'b1;
`endif

  logic clk;
  logic rst_n;

  process_scheduler_if #(.NPROC(4), .PID_W(2)) sif ();

  process_scheduler #(
    .NPROC  (4),
    .PID_W  (2),
    .QUANTUM(QUANTUM),
    .STRIDE (32'd1024)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compared;
  int          mismatched;
  logic [31:0] pc;
  logic [31:0] ref_table [4];
  logic [3:0]  ref_exited;
  int          ref_pid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_table[i] = i * 1024;
    ref_exited = 4'b0000;
    ref_pid    = 3;
  endtask

  function automatic int ref_next(input int cur, input logic [3:0] live);
    int s;
    for (int k = 1; k <= 4; k++) begin
      s = (cur + k) % 4;
      if (live[s]) return s;
    end
    return -1;
  endfunction

  // One clock: sample at the falling edge, advance the processor PC model.
  task automatic cyc();
    @(negedge clk);
    if (sif.load_pc_o) pc = sif.new_pc_o;
    else if (!sif.preempt_req_o && !sif.halted_i) pc = pc + $urandom_range(1, 4);
    sif.current_pc_i = pc;
  endtask

  task automatic wait_load(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cyc();
      if (sif.load_pc_o) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  // From LOAD (or RUN) until the stop request rises; counts non-halted RUN cycles.
  task automatic run_quantum(input bit rand_halt);
    int nh;
    bit done;
    nh   = 0;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (!sif.preempt_req_o && !sif.load_pc_o && !sif.idle_o) begin
        sif.halted_i = rand_halt ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (!sif.halted_i) nh++;
      end else begin
        sif.halted_i = 1'b0;
      end
      cyc();
      if (n == 0) chk("run_entry", {30'd0, sif.preempt_req_o, sif.load_pc_o}, 32'd0);
      if (sif.preempt_req_o) done = 1'b1;
    end
    sif.halted_i = 1'b0;
    chk("quantum_done", {31'd0, done}, 32'd1);
    chk("quantum_len", nh, QUANTUM);
  endtask

  // From the first DRAIN cycle: hold ack low, then ack and check the switch.
  task automatic finish_switch(input int hold, input bit was_exit);
    logic [3:0] live;
    int         exp;
    int         lat;
    bit         seen;
    bit         stop;
    if (was_exit) ref_exited[ref_pid] = 1'b1;
    else          ref_table[ref_pid]  = pc;
    live = sif.proc_ready_i & ~ref_exited;
    exp  = ref_next(ref_pid, live);
    for (int h = 0; h < hold; h++) begin
      sif.preempt_ack_i = 1'b0;
      cyc();
      chk("drain_hold", {30'd0, sif.preempt_req_o, sif.load_pc_o}, 32'd2);
    end
    sif.preempt_ack_i = 1'b1;
    lat  = 0;
    seen = 1'b0;
    stop = 1'b0;
    for (int n = 0; n < 8 && !stop; n++) begin
      cyc();
      sif.preempt_ack_i = 1'b0;
      lat++;
      if (sif.load_pc_o) begin
        seen = 1'b1;
        stop = 1'b1;
      end else if (sif.idle_o) begin
        stop = 1'b1;
      end
    end
    if (exp < 0) begin
      chk("nolive_load", {31'd0, seen}, 32'd0);
      chk("nolive_idle", {31'd0, sif.idle_o}, 32'd1);
      chk("nolive_req", {31'd0, sif.preempt_req_o}, 32'd0);
    end else begin
      chk("ack_to_load", lat, 32'd3);
      chk("next_pid", {30'd0, sif.pid_o}, exp);
      chk("next_pc", sif.new_pc_o, ref_table[exp]);
      chk("idle_low", {31'd0, sif.idle_o}, 32'd0);
      ref_pid = exp;
    end
  endtask

  task automatic pulse_exit();
    int n;
    n = $urandom_range(1, 8);
    repeat (n) cyc();
    sif.proc_exit_i = 1'b1;
    cyc();
    sif.proc_exit_i = 1'b0;
    chk("exit_req", {31'd0, sif.preempt_req_o}, 32'd1);
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    pc                = 32'd0;
    rst_n             = 1'b0;
    sif.enable_i      = 1'b0;
    sif.current_pc_i  = 32'd0;
    sif.halted_i      = 1'b0;
    sif.proc_ready_i  = 4'b0000;
    sif.proc_exit_i   = 1'b0;
    sif.preempt_ack_i = 1'b0;
    model_reset();

    repeat (3) cyc();
    chk("rst_idle", {31'd0, sif.idle_o}, 32'd1);
    chk("rst_req", {31'd0, sif.preempt_req_o}, 32'd0);
    chk("rst_load", {31'd0, sif.load_pc_o}, 32'd0);
    chk("rst_newpc", sif.new_pc_o, 32'd0);
    chk("rst_pid", {30'd0, sif.pid_o}, 32'd3);

    // Two ready slots, alternate with random halts and ack delays.
    sif.proc_ready_i = 4'b0011;
    sif.enable_i     = 1'b1;
    rst_n            = 1'b1;
    wait_load("first_load");
    chk("first_pid", {30'd0, sif.pid_o}, 32'd0);
    chk("first_pc", sif.new_pc_o, 32'd0);
    ref_pid = 0;
    for (int i = 0; i < 6; i++) begin
      run_quantum(RH);
      finish_switch((i == 0) ? 0 : ((i == 2) ? 10 : int'($urandom_range(0, 3))), 1'b0);
    end

    // Non-adjacent slots: 0 -> 3 -> 0 -> 3.
    sif.proc_ready_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      run_quantum(RH);
      finish_switch($urandom_range(0, 2), 1'b0);
    end

    // Back to 0011: 3 -> 0 -> 1, exit slot 1, then slot 0 alone, then exit it.
    sif.proc_ready_i = 4'b0011;
    run_quantum(RH);
    finish_switch(0, 1'b0);
    run_quantum(RH);
    finish_switch(0, 1'b0);
    pulse_exit();
    finish_switch($urandom_range(0, 2), 1'b1);
    run_quantum(RH);
    finish_switch(0, 1'b0);
    pulse_exit();
    finish_switch(0, 1'b1);
    repeat (4) cyc();
    chk("stay_idle", {30'd0, sif.idle_o, sif.load_pc_o}, 32'd2);

    // Reset in DRAIN after the table has been updated once.
    rst_n = 1'b0;
    repeat (2) cyc();
    model_reset();
    sif.proc_ready_i = 4'b0001;
    rst_n            = 1'b1;
    wait_load("rst2_load");
    chk("rst2_pc", sif.new_pc_o, 32'd0);
    ref_pid = 0;
    run_quantum(RH);
    finish_switch(0, 1'b0);
    chk("saved_nonzero", {31'd0, (sif.new_pc_o != 32'd0)}, 32'd1);
    run_quantum(RH);
    sif.preempt_ack_i = 1'b0;
    repeat (2) cyc();
    chk("drain_before_rst", {31'd0, sif.preempt_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, sif.preempt_req_o}, 32'd0);
    chk("async_idle", {31'd0, sif.idle_o}, 32'd1);
    chk("async_pid", {30'd0, sif.pid_o}, 32'd3);
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    wait_load("rst3_load");
    chk("rst3_pid", {30'd0, sif.pid_o}, 32'd0);
    chk("rst3_pc", sif.new_pc_o, 32'd0);
    ref_pid = 0;

    // Halted behaviour in RUN.
`ifdef SCHED_HALT_PREEMPT_EN
    cyc();
    sif.halted_i = 1'b1;
    cyc();
    sif.halted_i = 1'b0;
    chk("halt_yield", {31'd0, sif.preempt_req_o}, 32'd1);
    finish_switch(0, 1'b0);
    run_quantum(1'b0);
    finish_switch(0, 1'b0);
`else
    sif.halted_i = 1'b1;
    repeat (20) cyc();
    chk("halt_freeze", {31'd0, sif.preempt_req_o}, 32'd0);
    sif.halted_i = 1'b0;
    run_quantum(1'b0);
    finish_switch(0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
